// File: rtl/key_cmd_pkg.sv
// Shared definitions for the key command scheduler.
//   K1/K2/K3     : bit positions of each key in the 3-bit key vectors
//   arb_state_t  : command arbiter states
//   rep_state_t  : key2 auto-repeat states
//   pick_key     : fixed-priority selector (key1 > key3 > key2), one-hot or zero
package key_cmd_pkg;

    localparam int K1 = 0;
    localparam int K2 = 1;
    localparam int K3 = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKOUT
    } arb_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_RATE
    } rep_state_t;

    function automatic logic [2:0] pick_key(input logic [2:0] req);
        logic [2:0] sel;
        sel = '0;
        if (req[K1])      sel[K1] = 1'b1;
        else if (req[K3]) sel[K3] = 1'b1;
        else if (req[K2]) sel[K2] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key conditioning: 2-flop synchroniser, debounce counter and press edge.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   key_n   : raw active-low key, asynchronous to clk
//   stable  : debounced key state, 1 = pressed
//   press   : one-cycle pulse registered together with a 0->1 flip of stable
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic stable,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          sync_pressed;
    logic [CW-1:0] cnt;

    assign sync_pressed = ~sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync_pressed == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Mismatch held for DEBOUNCE_CYCLES samples: accept the new level.
                stable <= sync_pressed;
                press  <= sync_pressed;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Key command front end: conditions KEY[3:1], adds key2 auto-repeat and
// serialises the resulting events into single-cycle command pulses.
//   CLOCK_50      : system clock
//   key0_pressed  : synchronous active-high reset
//   key_n[2:0]    : raw active-low keys, bit0=KEY1, bit1=KEY2, bit2=KEY3
//   repeat_en     : enables key2 auto-repeat while high
//   key1/2/3_pressed : one-hot-or-zero registered command pulses
//   busy          : any key currently debounced as pressed
module key_cmd_scheduler
    import key_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int LOCKOUT_CYCLES  = 2
) (
    input  logic       CLOCK_50,
    input  logic       key0_pressed,
    input  logic [2:0] key_n,
    input  logic       repeat_en,
    output logic       key1_pressed,
    output logic       key2_pressed,
    output logic       key3_pressed,
    output logic       busy
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int LW   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

    logic [2:0] stable;
    logic [2:0] press;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (CLOCK_50),
            .rst    (key0_pressed),
            .key_n  (key_n[i]),
            .stable (stable[i]),
            .press  (press[i])
        );
    end

    assign busy = |stable;

    // ---------------- key2 auto-repeat ----------------
    rep_state_t    rep_state;
    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    always_comb begin
        rep_fire = 1'b0;
        if (repeat_en && stable[K2]) begin
            if (rep_state == R_DELAY && rep_cnt == DELAY_LAST) rep_fire = 1'b1;
            if (rep_state == R_RATE  && rep_cnt == RATE_LAST)  rep_fire = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (key0_pressed) begin
            rep_state <= R_IDLE;
            rep_cnt   <= '0;
        end else if (!repeat_en || !stable[K2]) begin
            rep_state <= R_IDLE;
            rep_cnt   <= '0;
        end else begin
            case (rep_state)
                R_IDLE: begin
                    rep_cnt <= '0;
                    if (press[K2]) rep_state <= R_DELAY;
                end
                R_DELAY: begin
                    if (rep_cnt == DELAY_LAST) begin
                        rep_state <= R_RATE;
                        rep_cnt   <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                R_RATE: begin
                    if (rep_cnt == RATE_LAST) rep_cnt <= '0;
                    else                      rep_cnt <= rep_cnt + 1'b1;
                end
                default: begin
                    rep_state <= R_IDLE;
                    rep_cnt   <= '0;
                end
            endcase
        end
    end

    // ---------------- pending + arbiter ----------------
    arb_state_t    arb_state;
    logic [LW-1:0] lock_cnt;
    logic [2:0]    pending;
    logic [2:0]    events;
    logic [2:0]    grant;
    logic [2:0]    pulse;
    logic          can_grant;

    always_comb begin
        events     = press;
        events[K2] = press[K2] | rep_fire;
    end

    // The last lockout cycle doubles as the idle decision cycle, so pulses
    // land exactly LOCKOUT_CYCLES+1 cycles apart under back-to-back demand.
    assign can_grant = (arb_state == IDLE) ||
                       (arb_state == LOCKOUT && lock_cnt == LOCK_LAST);
    assign grant     = can_grant ? pick_key(pending) : 3'b000;

    always_ff @(posedge CLOCK_50) begin
        if (key0_pressed) begin
            arb_state <= IDLE;
            lock_cnt  <= '0;
            pending   <= '0;
            pulse     <= '0;
        end else begin
            // An event on a key whose pending bit is set is absorbed by the OR.
            pending <= (pending | events) & ~grant;
            pulse   <= grant;
            if (|grant) begin
                arb_state <= GRANT;
                lock_cnt  <= '0;
            end else begin
                case (arb_state)
                    IDLE: lock_cnt <= '0;
                    GRANT: begin
                        arb_state <= LOCKOUT;
                        lock_cnt  <= '0;
                    end
                    LOCKOUT: begin
                        if (lock_cnt == LOCK_LAST) begin
                            arb_state <= IDLE;
                            lock_cnt  <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                    default: begin
                        arb_state <= IDLE;
                        lock_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign key1_pressed = pulse[K1];
    assign key2_pressed = pulse[K2];
    assign key3_pressed = pulse[K3];

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler with small timing parameters.
// Cycle c observes the outputs after the c-th edge following the first
// stimulus sample (cycle 0 = first low sample of key_n).
module tb_key_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_n;
    logic       repeat_en;
    logic       k1, k2, k3, busy;

    int checks = 0;
    int errors = 0;

    logic [2:0] stim   [0:63];
    logic       rst_v  [0:63];
    logic [2:0] exp_p  [0:63];
    logic       exp_b  [0:63];
    logic       chk_b  [0:63];

    key_cmd_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .LOCKOUT_CYCLES (2)
    ) dut (
        .CLOCK_50     (clk),
        .key0_pressed (rst),
        .key_n        (key_n),
        .repeat_en    (repeat_en),
        .key1_pressed (k1),
        .key2_pressed (k2),
        .key3_pressed (k3),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int cyc, input logic [2:0] obs, input logic [2:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    task automatic clear_vectors();
        for (int i = 0; i < 64; i++) begin
            stim[i]  = 3'b111;
            rst_v[i] = 1'b0;
            exp_p[i] = 3'b000;
            exp_b[i] = 1'b0;
            chk_b[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        key_n = 3'b111;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulses", 0, {k3, k2, k1}, 3'b000);
        check("reset_busy", 0, {2'b00, busy}, 3'b000);
    endtask

    task automatic run(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            key_n = stim[c];
            rst   = rst_v[c];
            @(posedge clk);
            #1;
            check(tag, c + 1, {k3, k2, k1}, exp_p[c + 1]);
            if (chk_b[c + 1]) check({tag, "_busy"}, c + 1, {2'b00, busy}, {2'b00, exp_b[c + 1]});
        end
        key_n = 3'b111;
        rst   = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        key_n     = 3'b111;
        repeat_en = 1'b0;

        // Clean press on KEY1: pulse at 8, busy over cycles 6..25.
        do_reset();
        clear_vectors();
        for (int i = 0; i < 20; i++) stim[i] = 3'b110;
        exp_p[8] = 3'b001;
        for (int i = 1; i <= 30; i++) begin
            chk_b[i] = 1'b1;
            exp_b[i] = (i >= 6 && i <= 25);
        end
        run("clean", 30);

        // Bouncy KEY3: one pulse at 12.
        do_reset();
        clear_vectors();
        for (int i = 0; i < 3; i++)  stim[i] = 3'b011;
        for (int i = 4; i < 19; i++) stim[i] = 3'b011;
        exp_p[12] = 3'b100;
        run("bounce", 24);

        // Three-cycle glitch on KEY2: nothing at all.
        do_reset();
        clear_vectors();
        for (int i = 0; i < 3; i++) stim[i] = 3'b101;
        for (int i = 1; i <= 16; i++) chk_b[i] = 1'b1;
        run("glitch", 16);

        // KEY1 and KEY2 together: key1 at 8, key2 at 11.
        do_reset();
        clear_vectors();
        for (int i = 0; i < 20; i++) stim[i] = 3'b100;
        exp_p[8]  = 3'b001;
        exp_p[11] = 3'b010;
        run("simul", 20);

        // Auto-repeat on KEY2 held 30 cycles.
        do_reset();
        clear_vectors();
        repeat_en = 1'b1;
        for (int i = 0; i < 30; i++) stim[i] = 3'b101;
        exp_p[8]  = 3'b010;
        exp_p[18] = 3'b010;
        exp_p[21] = 3'b010;
        exp_p[24] = 3'b010;
        exp_p[27] = 3'b010;
        exp_p[30] = 3'b010;
        run("repeat_on", 32);

        // Same stimulus without repeat: only the press pulse.
        do_reset();
        repeat_en = 1'b0;
        clear_vectors();
        for (int i = 0; i < 30; i++) stim[i] = 3'b101;
        exp_p[8] = 3'b010;
        for (int i = 30; i < 50; i++) stim[i] = 3'b111;
        run("repeat_off", 50);

        // Reset during debounce with KEY1 held: pulse only at 16.
        do_reset();
        clear_vectors();
        for (int i = 0; i < 24; i++) stim[i] = 3'b110;
        for (int i = 5; i <= 7; i++) rst_v[i] = 1'b1;
        exp_p[16] = 3'b001;
        run("reset_mid", 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
